// File: rtl/hcsr04_multi_ranger.sv
// Round-robin HC-SR04 ranging engine: one TRIG/ECHO ping at a time across NUM_CH sensors.
// Optional HCSR04_IRQ_EN adds a push interrupt (irq / irq_ack).
module hcsr04_multi_ranger #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 22,
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3800000,
  parameter int GUARD_CYCLES   = 6000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [NUM_CH-1:0]         echo_i,
  output logic [NUM_CH-1:0]         trig_o,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH):0]   res_ch,
  output logic [CNT_W-1:0]          res_width,
  output logic                      res_timeout,
  output logic                      overflow,
  output logic                      busy
`ifdef HCSR04_IRQ_EN
  ,
  output logic                      irq,
  input  logic                      irq_ack
`endif
);

  localparam int CH_W   = $clog2(NUM_CH) + 1;
  localparam int PH_MAX = (GUARD_CYCLES > TRIG_CYCLES) ? GUARD_CYCLES : TRIG_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  TRIG_LAST  = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]  GUARD_LAST = PH_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CH_W:0]    NUM_CH_W   = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GUARD
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   sync1_reg, sync2_reg;
  logic [PH_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]    tmr_reg, tmr_next;
  logic [CH_W-1:0]     rr_reg, sel_idx_reg;
  logic [NUM_CH-1:0]   sel_oh_reg;
  logic                echo_s;

  logic [NUM_CH-1:0]   rot_mask;
  logic [CH_W-1:0]     pick_off, pick_idx;
  logic [CH_W:0]       pick_sum;
  logic                pick_found;
  logic [NUM_CH-1:0]   pick_oh;

  logic                push, push_timeout;
  logic [CNT_W-1:0]    push_width;

  logic                res_valid_reg, res_timeout_reg, overflow_reg;
  logic [CH_W-1:0]     res_ch_reg;
  logic [CNT_W-1:0]    res_width_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= echo_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign echo_s = |(sync2_reg & sel_oh_reg);

  // Rotate the mask so bit 0 is the rr pointer; the lowest set bit is the next channel.
  assign rot_mask = NUM_CH'({ch_mask, ch_mask} >> rr_reg);

  always_comb begin
    pick_off   = '0;
    pick_found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot_mask[k]) begin
        pick_off   = CH_W'(k);
        pick_found = 1'b1;
      end
    end
  end

  assign pick_sum = {1'b0, rr_reg} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= NUM_CH_W) ? CH_W'(pick_sum - NUM_CH_W) : CH_W'(pick_sum);
  assign pick_oh  = NUM_CH'(1) << pick_idx;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (enable && |ch_mask) state_next = S_SELECT;
      S_SELECT:    state_next = pick_found ? S_TRIG : S_IDLE;
      S_TRIG:      if (cnt_reg == TRIG_LAST) state_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (echo_s)    state_next = S_MEASURE;
        else if (push) state_next = S_GUARD;
      end
      S_MEASURE:   if (push) state_next = S_GUARD;
      S_GUARD:     if (cnt_reg == GUARD_LAST)
                     state_next = (enable && |ch_mask) ? S_SELECT : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    push         = 1'b0;
    push_timeout = 1'b0;
    push_width   = tmr_reg;
    case (state_reg)
      S_WAIT_RISE: if (!echo_s && tmr_reg == TO_LAST) begin
        push = 1'b1; push_timeout = 1'b1; push_width = TO_VAL;
      end
      S_MEASURE: begin
        if (!echo_s) push = 1'b1;
        else if (tmr_reg == TO_LAST) begin
          push = 1'b1; push_timeout = 1'b1; push_width = TO_VAL;
        end
      end
      default: ;
    endcase
  end

  // tmr_reg is the rise timer in WAIT_RISE and the echo width in MEASURE.
  always_comb begin
    tmr_next = tmr_reg;
    case (state_reg)
      S_TRIG:      tmr_next = '0;
      S_WAIT_RISE: tmr_next = echo_s ? CNT_W'(1) : tmr_reg + CNT_W'(1);
      S_MEASURE:   if (echo_s && tmr_reg != TO_LAST) tmr_next = tmr_reg + CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg     <= '0;
      tmr_reg     <= '0;
      rr_reg      <= '0;
      sel_idx_reg <= '0;
      sel_oh_reg  <= '0;
    end else begin
      tmr_reg <= tmr_next;
      if ((state_reg == S_TRIG || state_reg == S_GUARD) && state_next == state_reg)
        cnt_reg <= cnt_reg + PH_W'(1);
      else
        cnt_reg <= '0;
      if (state_reg == S_SELECT && pick_found) begin
        sel_idx_reg <= pick_idx;
        sel_oh_reg  <= pick_oh;
        rr_reg      <= (pick_idx == LAST_CH) ? '0 : pick_idx + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid_reg   <= 1'b0;
      res_ch_reg      <= '0;
      res_width_reg   <= '0;
      res_timeout_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else if (push && (!res_valid_reg || res_ready)) begin
      res_valid_reg   <= 1'b1;
      res_ch_reg      <= sel_idx_reg;
      res_width_reg   <= push_width;
      res_timeout_reg <= push_timeout;
    end else if (push) begin
      overflow_reg    <= 1'b1;
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg   <= 1'b0;
    end
  end

`ifdef HCSR04_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clock) begin
    if (reset)        irq_reg <= 1'b0;
    else if (push)    irq_reg <= 1'b1;
    else if (irq_ack) irq_reg <= 1'b0;
  end
  assign irq = irq_reg;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_trig
    assign trig_o[gi] = (state_reg == S_TRIG) && sel_oh_reg[gi];
  end

  assign res_valid   = res_valid_reg;
  assign res_ch      = res_ch_reg;
  assign res_width   = res_width_reg;
  assign res_timeout = res_timeout_reg;
  assign overflow    = overflow_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_hcsr04_multi_ranger.sv
// Randomized bench for hcsr04_multi_ranger: the bench acts as the sensors and predicts
// channel order, echo widths and timeouts from the ranging rules.
module tb_hcsr04_multi_ranger;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 10;
  localparam int TRIG   = 4;
  localparam int TMO    = 200;
  localparam int GUARD  = 50;

  logic             clk = 1'b0;
  logic             reset, enable, res_ready;
  logic [3:0]       ch_mask, echo_i, trig_o;
  logic             res_valid, res_timeout, overflow, busy;
  logic [2:0]       res_ch;
  logic [CNT_W-1:0] res_width;
`ifdef HCSR04_IRQ_EN
  logic irq, irq_ack;
  initial irq_ack = 1'b0;
`endif

  hcsr04_multi_ranger #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GUARD)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .echo_i(echo_i),
    .trig_o(trig_o), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_width(res_width), .res_timeout(res_timeout), .overflow(overflow), .busy(busy)
`ifdef HCSR04_IRQ_EN
    , .irq(irq), .irq_ack(irq_ack)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Trig monitor: records (channel, pulse length) for every completed TRIG pulse.
  int trig_ch_q[$];
  int trig_len_q[$];
  int cur_len = 0;
  int cur_ch  = 0;
  always @(negedge clk) begin
    if (trig_o != 4'b0000) begin
      chk("trig_onehot", $countones(trig_o), 1);
      for (int i = 0; i < NUM_CH; i++) if (trig_o[i]) cur_ch = i;
      cur_len++;
    end else if (cur_len != 0) begin
      trig_ch_q.push_back(cur_ch);
      trig_len_q.push_back(cur_len);
      cur_len = 0;
    end
  end

  int rr_m = 0;
  int held_ch = 0, held_w = 0, held_to = 0;

  function automatic int model_pick(input logic [3:0] m, input int r);
    for (int k = 0; k < NUM_CH; k++)
      if (m[(r + k) % NUM_CH]) return (r + k) % NUM_CH;
    return -1;
  endfunction

  task automatic do_pop();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("pop_valid", res_valid, 0);
  endtask

  task automatic wait_trig(output int ch, output int len, output bit ok);
    int n = 0;
    while (trig_ch_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (trig_ch_q.size() != 0);
    ch = -1; len = 0;
    if (!ok) chk("trig_wait", 0, 1);
    else begin
      ch  = trig_ch_q.pop_front();
      len = trig_len_q.pop_front();
    end
  endtask

  // mode 0: check+pop, 1: check and hold, 2: pop at the push edge, 3: result dropped
  task automatic ping(input int w, input int mode, input bit drop_en);
    int exp_ch, exp_w, exp_to, got_ch, got_len, n;
    bit ok;
    exp_ch = model_pick(ch_mask, rr_m);
    rr_m   = (exp_ch + 1) % NUM_CH;
    wait_trig(got_ch, got_len, ok);
    if (!ok) return;
    chk("trig_ch", got_ch, exp_ch);
    chk("trig_len", got_len, TRIG);
    if (drop_en) enable = 1'b0;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    if (w > 0) begin
      echo_i[exp_ch] = 1'b1;
      repeat (w) @(negedge clk);
      echo_i[exp_ch] = 1'b0;
    end
    exp_to = (w == 0 || w >= TMO) ? 1 : 0;
    exp_w  = exp_to ? TMO : w;
    $display("ping ch=%0d echo=%0d mode=%0d exp_width=%0d exp_timeout=%0d",
             exp_ch, w, mode, exp_w, exp_to);
    if (mode == 2) begin
      repeat (2) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("pp_valid", res_valid, 1);
      chk("pp_width", res_width, exp_w);
      chk("pp_ch", res_ch, exp_ch);
      chk("pp_overflow", overflow, 0);
      held_ch = exp_ch; held_w = exp_w; held_to = exp_to;
      do_pop();
      return;
    end
    if (mode == 3) begin
      repeat (6) @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_held_width", res_width, held_w);
      chk("bp_held_ch", res_ch, held_ch);
      chk("bp_held_timeout", res_timeout, held_to);
      chk("bp_overflow", overflow, 1);
      do_pop();
      return;
    end
    n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid", res_valid, 1);
    chk("res_ch", res_ch, exp_ch);
    chk("res_width", res_width, exp_w);
    chk("res_timeout", res_timeout, exp_to);
    held_ch = exp_ch; held_w = exp_w; held_to = exp_to;
    if (mode == 0) do_pop();
  endtask

  initial begin
    int a, c, n, ch, len;
    bit ok;
    reset = 1'b1; enable = 1'b0; ch_mask = 4'b0000; echo_i = 4'b0000; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", trig_o, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_width", res_width, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_enable", busy, 0);

    ch_mask = 4'b0001; enable = 1'b1;
    ping(37, 0, 0);

    ch_mask = 4'b1011;
    repeat (8) ping($urandom_range(1, 180), 0, 0);

    ch_mask = 4'b0100;
    ping(0, 0, 0);
    ping(250, 0, 0);
    ping(199, 0, 0);

    ch_mask = 4'b0001;
    a = $urandom_range(10, 60);
    ping(a, 1, 0);
    ping(a + 30, 2, 0);

    c = $urandom_range(10, 60);
    ping(c, 1, 0);
    ping(c + 25, 3, 0);
    chk("ovf_sticky", overflow, 1);

    ping($urandom_range(5, 90), 0, 1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("disable_idle", busy, 0);
    repeat (100) @(negedge clk);
    chk("disable_no_trig", trig_ch_q.size(), 0);

    enable = 1'b1;
    wait_trig(ch, len, ok);
    if (ok) chk("rst_ping_ch", ch, model_pick(ch_mask, rr_m));
    echo_i[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("measure_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_trig", trig_o, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_width", res_width, 0);
    enable = 1'b0; echo_i = 4'b0000;
    reset = 1'b0;
    rr_m = 0;
    repeat (60) @(negedge clk);
    chk("postrst_valid", res_valid, 0);
    chk("postrst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
